d_cache_wb: RTL and testbench

//  Parametrised direct-mapped write-back, write-allocate data cache between the MIPS core data port and the AXI bridge.

---
 rtl/d_cache_pkg.sv | 39 +++
 rtl/d_cache_line_ram.sv | 58 +++++
 rtl/d_cache_wb.sv | 262 ++++++++++++++++++++++++++
 tb/tb_d_cache_wb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_pkg.sv
// -----------------------------------------------------------------------------
// d_cache_pkg
// Shared definitions for the write-back data cache:
//   state_t      - controller FSM states
//   SIZE_*       - sram-like transfer size encodings
//   is_kseg1()   - decode of the uncached kseg1 window (0xA000_0000-0xBFFF_FFFF)
//   byte_mask()  - per-byte write enable from transfer size and addr[1:0]
// -----------------------------------------------------------------------------
package d_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP,
    ST_WB,
    ST_REFILL,
    ST_UNC
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic is_kseg1(input logic [31:0] addr);
    return addr[31:29] == 3'b101;
  endfunction

  // Requests are naturally aligned, so a half only ever sits at lane 0 or 2.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << lo;
      SIZE_HALF: mask = 4'b0011 << lo;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/d_cache_line_ram.sv
// -----------------------------------------------------------------------------
// d_cache_line_ram
// Tag and data storage for the direct-mapped cache: SETS entries of
// TAG_WIDTH + LINE_WORDS*32 bits. Writes are synchronous, one word per cycle
// with a 4-bit byte enable; the tag has its own write enable. Reads are
// asynchronous and return the whole line plus tag of the addressed set.
// Ports:
//   clk        clock
//   index      set index for both read and write
//   word_sel   word within the line to write
//   word_be    byte enables for the write (0 = no data write)
//   word_data  write data, lane-aligned
//   tag_we     tag write enable
//   tag_data   tag to write
//   rd_tag     tag of the indexed set
//   rd_line    all words of the indexed set
// -----------------------------------------------------------------------------
module d_cache_line_ram #(
  parameter int INDEX_WIDTH    = 7,
  parameter int TAG_WIDTH      = 21,
  parameter int LINE_WORDS     = 4,
  parameter int WORD_SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic [INDEX_WIDTH-1:0]    index,
  input  logic [WORD_SEL_WIDTH-1:0] word_sel,
  input  logic [3:0]                word_be,
  input  logic [31:0]               word_data,
  input  logic                      tag_we,
  input  logic [TAG_WIDTH-1:0]      tag_data,
  output logic [TAG_WIDTH-1:0]      rd_tag,
  output logic [31:0]               rd_line [LINE_WORDS]
);

  localparam int SETS = 2 ** INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] tag_mem  [SETS];
  logic [31:0]          data_mem [SETS][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[index] <= tag_data;
    end
    for (int b = 0; b < 4; b++) begin
      if (word_be[b]) begin
        data_mem[index][word_sel][8*b +: 8] <= word_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_tag = tag_mem[index];
    for (int w = 0; w < LINE_WORDS; w++) begin
      rd_line[w] = data_mem[index][w];
    end
  end

endmodule

// File: rtl/d_cache_wb.sv
// -----------------------------------------------------------------------------
// d_cache_wb
// Direct-mapped, write-back, write-allocate data cache between the core data
// port and the AXI bridge, both using the sram-like req/addr_ok/data_ok
// handshake. kseg1 addresses bypass the cache as single uncached transfers.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   cpu_data_*          core side: req/wr/size/addr/wdata in,
//                       rdata/addr_ok/data_ok out
//   cache_data_*        bridge side: req/wr/size/addr/wdata out,
//                       rdata/addr_ok/data_ok in
// Only one core request is in flight; the bridge sees at most one outstanding
// word at a time (req held to addr_ok, then wait for data_ok).
// -----------------------------------------------------------------------------
module d_cache_wb
  import d_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS       = 2 ** INDEX_WIDTH;
  localparam int LINE_WORDS = 2 ** (OFFSET_WIDTH - 2);
  localparam int CNT_WIDTH  = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(LINE_WORDS - 1);

  state_t state, state_next;

  logic                   req_wr;
  logic [1:0]             req_size;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  logic [SETS-1:0]        valid;
  logic [SETS-1:0]        dirty;
  logic [CNT_WIDTH-1:0]   word_cnt;
  logic                   issued;
  logic [31:0]            unc_rdata;

  logic [INDEX_WIDTH-1:0] req_index;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic [CNT_WIDTH-1:0]   req_word;
  logic [3:0]             req_mask;
  logic [31:0]            rd_line [LINE_WORDS];
  logic                   uncached;
  logic                   hit;
  logic                   victim_dirty;
  logic                   bridge_busy;
  logic                   word_done;
  logic                   last_word;
  logic [31:0]            line_off;
  logic [31:0]            wb_addr;
  logic [31:0]            refill_addr;

  logic [CNT_WIDTH-1:0]   ram_sel;
  logic [3:0]             ram_be;
  logic [31:0]            ram_data;
  logic                   ram_tag_we;

  assign req_index = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag   = req_addr[31 -: TAG_WIDTH];
  assign req_mask  = byte_mask(req_size, req_addr[1:0]);
  assign uncached  = is_kseg1(req_addr);

  generate
    if (LINE_WORDS > 1) begin : g_multi_word
      assign req_word = req_addr[2 +: CNT_WIDTH];
    end else begin : g_single_word
      assign req_word = '0;
    end
  endgenerate

  d_cache_line_ram #(
    .INDEX_WIDTH   (INDEX_WIDTH),
    .TAG_WIDTH     (TAG_WIDTH),
    .LINE_WORDS    (LINE_WORDS),
    .WORD_SEL_WIDTH(CNT_WIDTH)
  ) u_line_ram (
    .clk      (clk),
    .index    (req_index),
    .word_sel (ram_sel),
    .word_be  (ram_be),
    .word_data(ram_data),
    .tag_we   (ram_tag_we),
    .tag_data (req_tag),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  assign hit          = valid[req_index] && (rd_tag == req_tag) && !uncached;
  assign victim_dirty = valid[req_index] && dirty[req_index];
  assign bridge_busy  = (state == ST_WB) || (state == ST_REFILL) || (state == ST_UNC);
  assign last_word    = (word_cnt == LAST_WORD);

  // A word completes on data_ok once its address phase is done, including the
  // case where addr_ok and data_ok arrive together.
  assign word_done = bridge_busy && cache_data_data_ok &&
                     (issued || (cache_data_req && cache_data_addr_ok));

  assign line_off    = {{(32 - CNT_WIDTH - 2){1'b0}}, word_cnt, 2'b00};
  assign wb_addr     = {rd_tag,  req_index, {OFFSET_WIDTH{1'b0}}} | line_off;
  assign refill_addr = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}} | line_off;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cpu_data_req) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (uncached)          state_next = ST_UNC;
        else if (hit)          state_next = ST_RESP;
        else if (victim_dirty) state_next = ST_WB;
        else                   state_next = ST_REFILL;
      end
      ST_WB: begin
        if (word_done && last_word) state_next = ST_REFILL;
      end
      ST_REFILL: begin
        if (word_done && last_word) state_next = ST_RESP;
      end
      ST_UNC: begin
        if (word_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs. addr_ok is gated by rst because it is combinational from the
  // core's req and must stay low while reset is held.
  always_comb begin
    cpu_data_addr_ok = (state == ST_IDLE) && cpu_data_req && rst;
    cpu_data_data_ok = (state == ST_RESP);
    cpu_data_rdata   = '0;
    cache_data_req   = bridge_busy && !issued;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'd0;
    cache_data_addr  = '0;
    cache_data_wdata = '0;
    if (state == ST_RESP) begin
      cpu_data_rdata = uncached ? unc_rdata : rd_line[req_word];
    end
    case (state)
      ST_WB: begin
        cache_data_wr    = 1'b1;
        cache_data_size  = SIZE_WORD;
        cache_data_addr  = wb_addr;
        cache_data_wdata = rd_line[word_cnt];
      end
      ST_REFILL: begin
        cache_data_size  = SIZE_WORD;
        cache_data_addr  = refill_addr;
      end
      ST_UNC: begin
        cache_data_wr    = req_wr;
        cache_data_size  = req_size;
        cache_data_addr  = req_addr;
        cache_data_wdata = req_wdata;
      end
      default: ;
    endcase
  end

  // Line RAM write port. A store that missed is folded into the refill of its
  // own word, so the line is complete and merged when the last word lands.
  always_comb begin
    ram_sel    = req_word;
    ram_be     = '0;
    ram_data   = req_wdata;
    ram_tag_we = 1'b0;
    if (state == ST_LOOKUP && hit && req_wr) begin
      ram_be = req_mask;
    end else if (state == ST_REFILL && word_done) begin
      ram_sel    = word_cnt;
      ram_be     = 4'hF;
      ram_tag_we = last_word;
      for (int b = 0; b < 4; b++) begin
        ram_data[8*b +: 8] = (req_wr && (word_cnt == req_word) && req_mask[b]) ?
                             req_wdata[8*b +: 8] : cache_data_rdata[8*b +: 8];
      end
    end
  end

  // Request latches, bridge handshake tracking, word counter and line status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wr    <= 1'b0;
      req_size  <= 2'd0;
      req_addr  <= '0;
      req_wdata <= '0;
      issued    <= 1'b0;
      word_cnt  <= '0;
      unc_rdata <= '0;
      valid     <= '0;
      dirty     <= '0;
    end else begin
      if (cpu_data_addr_ok) begin
        req_wr    <= cpu_data_wr;
        req_size  <= cpu_data_size;
        req_addr  <= cpu_data_addr;
        req_wdata <= cpu_data_wdata;
      end

      if (!bridge_busy || word_done) begin
        issued <= 1'b0;
      end else if (cache_data_req && cache_data_addr_ok) begin
        issued <= 1'b1;
      end

      if (word_done && state != ST_UNC) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end

      if (state == ST_UNC && word_done) begin
        unc_rdata <= cache_data_rdata;
      end

      if (state == ST_LOOKUP && hit && req_wr) begin
        dirty[req_index] <= 1'b1;
      end

      if (state == ST_REFILL && word_done && last_word) begin
        valid[req_index] <= 1'b1;
        dirty[req_index] <= req_wr;
      end
    end
  end

endmodule

// File: tb/tb_d_cache_wb.sv
// -----------------------------------------------------------------------------
// tb_d_cache_wb
// Self-checking bench for d_cache_wb. A bridge model with configurable latency
// serves a flat memory and logs every accepted transfer. A reference model
// tracks the architectural memory view and per-set valid/dirty/tag, and from
// those predicts the exact bridge traffic and load data for each access.
// -----------------------------------------------------------------------------
module tb_d_cache_wb;

  localparam int SETS = 128;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_data_req = 1'b0;
  logic        cpu_data_wr = 1'b0;
  logic [1:0]  cpu_data_size = 2'd0;
  logic [31:0] cpu_data_addr = '0;
  logic [31:0] cpu_data_wdata = '0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata = '0;
  logic        cache_data_addr_ok = 1'b0;
  logic        cache_data_data_ok = 1'b0;

  always #5 clk = ~clk;

  d_cache_wb #(.INDEX_WIDTH(7), .OFFSET_WIDTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_data_req      (cpu_data_req),
    .cpu_data_wr       (cpu_data_wr),
    .cpu_data_size     (cpu_data_size),
    .cpu_data_addr     (cpu_data_addr),
    .cpu_data_wdata    (cpu_data_wdata),
    .cpu_data_rdata    (cpu_data_rdata),
    .cpu_data_addr_ok  (cpu_data_addr_ok),
    .cpu_data_data_ok  (cpu_data_data_ok),
    .cache_data_req    (cache_data_req),
    .cache_data_wr     (cache_data_wr),
    .cache_data_size   (cache_data_size),
    .cache_data_addr   (cache_data_addr),
    .cache_data_wdata  (cache_data_wdata),
    .cache_data_rdata  (cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok),
    .cache_data_data_ok(cache_data_data_ok)
  );

  int vectors = 0;
  int miscompares = 0;
  int overlap_cnt = 0;
  int bridge_lat = 3;
  bit same_cycle = 1'b0;

  txn_t log_q[$];
  txn_t exp_q[$];
  logic [31:0] bmem     [logic [31:0]];
  logic [31:0] arch_mem [logic [31:0]];
  logic        m_valid [SETS];
  logic        m_dirty [SETS];
  logic [20:0] m_tag   [SETS];

  // Bridge model state.
  int          wait_cnt = 0;
  int          pend_cnt = 0;
  bit          pending = 1'b0;
  logic [31:0] pend_addr = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] m;
    case (size)
      2'd0:    m = 32'h0000_00FF << (8 * lo);
      2'd1:    m = 32'h0000_FFFF << (8 * lo);
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | (data & m);
  endfunction

  // Bridge: accepts a request after bridge_lat cycles of req, then returns
  // data_ok bridge_lat cycles later (or together with addr_ok in same_cycle mode).
  initial begin : bridge_model
    txn_t        t;
    logic [31:0] aligned;
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (!rst) begin
        wait_cnt = 0;
        pending  = 1'b0;
      end else if (pending) begin
        if (cache_data_req) overlap_cnt++;
        if (pend_cnt >= bridge_lat - 1) begin
          cache_data_data_ok = 1'b1;
          cache_data_rdata   = bmem_rd(pend_addr);
          pending            = 1'b0;
        end else begin
          pend_cnt++;
        end
      end else if (cache_data_req) begin
        if (wait_cnt >= bridge_lat - 1) begin
          wait_cnt = 0;
          cache_data_addr_ok = 1'b1;
          t.wr    = cache_data_wr;
          t.size  = cache_data_size;
          t.addr  = cache_data_addr;
          t.wdata = cache_data_wdata;
          log_q.push_back(t);
          aligned = {cache_data_addr[31:2], 2'b00};
          if (cache_data_wr) begin
            bmem[aligned] = merge_lane(bmem_rd(aligned), cache_data_wdata,
                                       cache_data_size, cache_data_addr[1:0]);
          end
          if (same_cycle) begin
            cache_data_data_ok = 1'b1;
            cache_data_rdata   = bmem_rd(aligned);
          end else begin
            pending   = 1'b1;
            pend_cnt  = 0;
            pend_addr = aligned;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Reference model: predicts bridge traffic and load data for one access.
  task automatic modelAccess(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] exp_rdata,
                             output bit exp_hit);
    logic [6:0]  idx;
    logic [20:0] tag;
    logic [31:0] a;
    txn_t        t;
    bit          cached;
    idx = addr[10:4];
    tag = addr[31:11];
    cached = (addr[31:29] != 3'b101);
    exp_q.delete();
    exp_hit = 1'b0;
    if (!cached) begin
      t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
      exp_q.push_back(t);
    end else if (m_valid[idx] && m_tag[idx] == tag) begin
      exp_hit = 1'b1;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int w = 0; w < 4; w++) begin
          a = {m_tag[idx], idx, 4'(w * 4)};
          t.wr = 1'b1; t.size = 2'd2; t.addr = a; t.wdata = arch_rd(a);
          exp_q.push_back(t);
        end
      end
      for (int w = 0; w < 4; w++) begin
        t.wr = 1'b0; t.size = 2'd2; t.addr = {tag, idx, 4'(w * 4)}; t.wdata = '0;
        exp_q.push_back(t);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      a = {addr[31:2], 2'b00};
      arch_mem[a] = merge_lane(arch_rd(a), wdata, size, addr[1:0]);
      if (cached) m_dirty[idx] = 1'b1;
    end
    exp_rdata = arch_rd({addr[31:2], 2'b00});
  endtask

  task automatic modelReset();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    arch_mem = bmem;
  endtask

  // Drives one core request and measures addr_ok -> data_ok latency.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    #1;
    n = 0;
    while (!cpu_data_addr_ok && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("addr_ok", 32'(cpu_data_addr_ok), 32'd1);
    @(posedge clk);
    #1;
    cpu_data_req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_data_data_ok && lat < 300);
    checkOutput("data_ok", 32'(cpu_data_data_ok), 32'd1);
    rdata = cpu_data_rdata;
    @(negedge clk);
    checkOutput("data_ok_pulse", 32'(cpu_data_data_ok), 32'd0);
  endtask

  task automatic compareTraffic(input string name);
    checkOutput({name, "_txn_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checkOutput({name, "_txn_wr"},   32'(log_q[i].wr),   32'(exp_q[i].wr));
      checkOutput({name, "_txn_size"}, 32'(log_q[i].size), 32'(exp_q[i].size));
      checkOutput({name, "_txn_addr"}, log_q[i].addr,      exp_q[i].addr);
      if (exp_q[i].wr) checkOutput({name, "_txn_wdata"}, log_q[i].wdata, exp_q[i].wdata);
    end
  endtask

  task automatic doAccess(input string name, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd;
    logic [31:0] rd;
    bit          hit;
    int          lat;
    modelAccess(wr, size, addr, wdata, exp_rd, hit);
    log_q.delete();
    applyStimulus(wr, size, addr, wdata, rd, lat);
    compareTraffic(name);
    if (!wr) checkOutput({name, "_rdata"}, rd, exp_rd);
    if (hit && !wr) checkOutput({name, "_hit_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_cpu_ok"},  {30'd0, cpu_data_addr_ok, cpu_data_data_ok}, 32'd0);
    checkOutput({name, "_cpu_rdata"}, cpu_data_rdata, 32'd0);
    checkOutput({name, "_bridge_ctl"}, {28'd0, cache_data_req, cache_data_wr, cache_data_size}, 32'd0);
    checkOutput({name, "_bridge_addr"}, cache_data_addr, 32'd0);
    checkOutput({name, "_bridge_wdata"}, cache_data_wdata, 32'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int          n;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] off;
    modelReset();

    // Reset with a core request pending: nothing may leak out.
    cpu_data_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    cpu_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Cold miss, then hit.
    bridge_lat = 3;
    doAccess("cold_load", 1'b0, 2'd2, 32'h0000_1040, '0);
    doAccess("hit_load", 1'b0, 2'd2, 32'h0000_1040, '0);

    // Store byte on a resident line, then read back the word.
    doAccess("hit_store_byte", 1'b1, 2'd0, 32'h0000_1041, 32'h0000_AB00);
    doAccess("load_after_store", 1'b0, 2'd2, 32'h0000_1040, '0);

    // Conflict miss evicting the dirty line.
    doAccess("dirty_evict", 1'b0, 2'd2, 32'h0000_9040, '0);

    // Uncached half loads from kseg1, twice.
    doAccess("unc_half_1", 1'b0, 2'd1, 32'hBFC0_0002, '0);
    doAccess("unc_half_2", 1'b0, 2'd1, 32'hBFC0_0002, '0);

    // Reset in the middle of a refill (third word accepted).
    log_q.delete();
    @(negedge clk);
    cpu_data_req   = 1'b1;
    cpu_data_wr    = 1'b0;
    cpu_data_size  = 2'd2;
    cpu_data_addr  = 32'h0000_3080;
    n = 0;
    while (log_q.size() < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_reached_word2", 32'(log_q.size()), 32'd3);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkResetOutputs("mid_reset");
    end
    cpu_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    doAccess("after_reset_load", 1'b0, 2'd2, 32'h0000_3084, '0);

    // Bridge answers addr_ok and data_ok together.
    same_cycle = 1'b1;
    bridge_lat = 1;
    doAccess("same_cycle_refill", 1'b0, 2'd2, 32'h0000_4108, '0);
    doAccess("same_cycle_unc_store", 1'b1, 2'd2, 32'hA000_0010, 32'h1234_5678);
    doAccess("same_cycle_unc_load", 1'b0, 2'd2, 32'hA000_0010, '0);

    // Randomized mix over a few conflicting sets plus kseg1.
    for (int k = 0; k < 300; k++) begin
      bridge_lat = $urandom_range(1, 3);
      same_cycle = ($urandom_range(0, 3) == 0);
      sz  = 2'($urandom_range(0, 2));
      off = 32'($urandom_range(0, 15));
      if (sz == 2'd1) off = off & 32'hE;
      if (sz == 2'd2) off = off & 32'hC;
      if ($urandom_range(0, 9) == 0) begin
        addr = 32'hA000_1000 | off;
      end else begin
        addr = {21'($urandom_range(1, 4)), 7'($urandom_range(0, 3) * 9 + 2), off[3:0]};
      end
      doAccess("random", 1'($urandom_range(0, 1)), sz, addr, $urandom);
    end

    checkOutput("bridge_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
